// File: rtl/uart_frame_check.sv
// ---------------------------------------------------------------------------
// uart_frame_check
//
// Purpose:
//   Back end of a UART receiver. Once the front end confirms a start bit and
//   delivers majority-voted bits one strobe at a time, this block assembles
//   the data bits and checks the optional parity bit and the one or two stop
//   bits. It then publishes the completed frame together with its error
//   flags, and keeps saturating counts of parity and stop errors.
//
// Parameters:
//   DATA_W      data bits per frame (5..9)
//   CNT_W       width of each error counter
//
// Ports:
//   CLK         clock, all state changes on its rising edge
//   RST         synchronous active-high reset, overrides every other input
//   start_det   start bit confirmed; begins (or restarts) a frame
//   bit_valid   one-cycle strobe, sampled_bit holds the next frame bit
//   sampled_bit majority-voted line value
//   PAR_EN      parity bit present (latched at frame start)
//   PAR_TYP     00 even, 01 odd, 10 mark, 11 space (latched at frame start)
//   STOP2       two stop bits when 1 (latched at frame start)
//   clr_cnt     clears both error counters, wins over an increment
//   P_DATA      data of the last completed frame (first line bit in LSB)
//   data_valid  one-cycle pulse per completed frame
//   par_err     parity error of the last completed frame
//   stp_err     stop error of the last completed frame
//   par_err_cnt saturating count of parity errors
//   stp_err_cnt saturating count of stop errors
//   busy        high whenever a frame is in progress
// ---------------------------------------------------------------------------
module uart_frame_check #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start_det,
    input  logic              bit_valid,
    input  logic              sampled_bit,
    input  logic              PAR_EN,
    input  logic [1:0]        PAR_TYP,
    input  logic              STOP2,
    input  logic              clr_cnt,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic [CNT_W-1:0]  par_err_cnt,
    output logic [CNT_W-1:0]  stp_err_cnt,
    output logic              busy
);

    // The bit counter only has to reach DATA_W-1; the value it wraps to after
    // the last data bit is never looked at because the FSM has left DATA.
    localparam int               BC_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_e;

    state_e              state_q,     state_d;
    logic [DATA_W-1:0]   shiftReg_q,  shiftReg_d;
    logic [BC_W-1:0]     bitCnt_q,    bitCnt_d;
    logic                runPar_q,    runPar_d;
    logic                cfgParEn_q,  cfgParEn_d;
    logic [1:0]          cfgParTyp_q, cfgParTyp_d;
    logic                cfgStop2_q,  cfgStop2_d;
    logic                parFlag_q,   parFlag_d;
    logic                stopBad_q,   stopBad_d;
    logic [DATA_W-1:0]   pData_q,     pData_d;
    logic                dataValid_q, dataValid_d;
    logic                parErr_q,    parErr_d;
    logic                stpErr_q,    stpErr_d;
    logic [CNT_W-1:0]    parErrCnt_q, parErrCnt_d;
    logic [CNT_W-1:0]    stpErrCnt_q, stpErrCnt_d;

    logic                expParity;
    logic                frameDone;

    // Expected value of the parity bit, derived only from the configuration
    // captured at frame start so that mid-frame changes to PAR_TYP are inert.
    always_comb begin
        expParity = 1'b0;
        case (cfgParTyp_q)
            2'b00:   expParity = runPar_q;
            2'b01:   expParity = ~runPar_q;
            2'b10:   expParity = 1'b1;
            default: expParity = 1'b0;
        endcase
    end

    // Next-state and datapath logic.
    // start_det has priority over bit_valid in every state: it both starts a
    // frame from IDLE and aborts a partial frame, and a bit strobe arriving in
    // the same cycle is dropped. Without a strobe nothing in the frame moves.
    // frameDone marks the cycle whose final stop-bit strobe closes the frame;
    // the published outputs below are loaded on that same edge, so they become
    // visible one cycle after the strobe.
    always_comb begin
        state_d     = state_q;
        shiftReg_d  = shiftReg_q;
        bitCnt_d    = bitCnt_q;
        runPar_d    = runPar_q;
        cfgParEn_d  = cfgParEn_q;
        cfgParTyp_d = cfgParTyp_q;
        cfgStop2_d  = cfgStop2_q;
        parFlag_d   = parFlag_q;
        stopBad_d   = stopBad_q;
        frameDone   = 1'b0;

        if (start_det) begin
            state_d     = S_DATA;
            shiftReg_d  = '0;
            bitCnt_d    = '0;
            runPar_d    = 1'b0;
            parFlag_d   = 1'b0;
            stopBad_d   = 1'b0;
            cfgParEn_d  = PAR_EN;
            cfgParTyp_d = PAR_TYP;
            cfgStop2_d  = STOP2;
        end else if (bit_valid) begin
            case (state_q)
                S_DATA: begin
                    // Line is LSB first, so each new bit enters at the MSB
                    // and the first bit ends up in bit 0.
                    shiftReg_d = {sampled_bit, shiftReg_q[DATA_W-1:1]};
                    runPar_d   = runPar_q ^ sampled_bit;
                    bitCnt_d   = bitCnt_q + 1'b1;
                    if (bitCnt_q == LAST_BIT) begin
                        state_d = cfgParEn_q ? S_PARITY : S_STOP1;
                    end
                end
                S_PARITY: begin
                    parFlag_d = (sampled_bit != expParity);
                    state_d   = S_STOP1;
                end
                S_STOP1: begin
                    stopBad_d = ~sampled_bit;
                    if (cfgStop2_q) begin
                        state_d = S_STOP2;
                    end else begin
                        state_d   = S_IDLE;
                        frameDone = 1'b1;
                    end
                end
                S_STOP2: begin
                    // A bad first stop bit is remembered, but the second one
                    // is still consumed before the frame closes.
                    stopBad_d = stopBad_q | ~sampled_bit;
                    state_d   = S_IDLE;
                    frameDone = 1'b1;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Published results and error counters.
    // The frame outputs only change on completion and hold otherwise. The
    // parity flag is masked when parity was disabled for the frame so a stale
    // flag can never leak out. The counters saturate, and a clear request
    // beats a simultaneous increment.
    always_comb begin
        pData_d     = pData_q;
        dataValid_d = frameDone;
        parErr_d    = parErr_q;
        stpErr_d    = stpErr_q;
        parErrCnt_d = parErrCnt_q;
        stpErrCnt_d = stpErrCnt_q;

        if (frameDone) begin
            pData_d  = shiftReg_q;
            parErr_d = parFlag_q & cfgParEn_q;
            stpErr_d = stopBad_d;
        end

        if (clr_cnt) begin
            parErrCnt_d = '0;
            stpErrCnt_d = '0;
        end else if (frameDone) begin
            if (parErr_d && (parErrCnt_q != CNT_MAX)) begin
                parErrCnt_d = parErrCnt_q + 1'b1;
            end
            if (stpErr_d && (stpErrCnt_q != CNT_MAX)) begin
                stpErrCnt_d = stpErrCnt_q + 1'b1;
            end
        end
    end

    // State register. Reset is synchronous and beats start_det, bit_valid and
    // clr_cnt, so a frame interrupted by reset is simply thrown away,
    // including one whose final stop bit arrives in the reset cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            shiftReg_q  <= '0;
            bitCnt_q    <= '0;
            runPar_q    <= 1'b0;
            cfgParEn_q  <= 1'b0;
            cfgParTyp_q <= 2'b00;
            cfgStop2_q  <= 1'b0;
            parFlag_q   <= 1'b0;
            stopBad_q   <= 1'b0;
            pData_q     <= '0;
            dataValid_q <= 1'b0;
            parErr_q    <= 1'b0;
            stpErr_q    <= 1'b0;
            parErrCnt_q <= '0;
            stpErrCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shiftReg_q  <= shiftReg_d;
            bitCnt_q    <= bitCnt_d;
            runPar_q    <= runPar_d;
            cfgParEn_q  <= cfgParEn_d;
            cfgParTyp_q <= cfgParTyp_d;
            cfgStop2_q  <= cfgStop2_d;
            parFlag_q   <= parFlag_d;
            stopBad_q   <= stopBad_d;
            pData_q     <= pData_d;
            dataValid_q <= dataValid_d;
            parErr_q    <= parErr_d;
            stpErr_q    <= stpErr_d;
            parErrCnt_q <= parErrCnt_d;
            stpErrCnt_q <= stpErrCnt_d;
        end
    end

    assign P_DATA      = pData_q;
    assign data_valid  = dataValid_q;
    assign par_err     = parErr_q;
    assign stp_err     = stpErr_q;
    assign par_err_cnt = parErrCnt_q;
    assign stp_err_cnt = stpErrCnt_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_check.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_check
//
// Purpose:
//   Self-checking bench for uart_frame_check. Two instances share the same
//   stimulus: one with default parameters and one with 2-bit error counters
//   so that counter saturation is reachable in a handful of frames.
//   Frames are table driven; the abort, reset, idle-strobe, mid-frame
//   configuration and counter clear cases are written out by hand.
// ---------------------------------------------------------------------------
module tb_uart_frame_check;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start_det;
    logic       bit_valid;
    logic       sampled_bit;
    logic       PAR_EN;
    logic [1:0] PAR_TYP;
    logic       STOP2;
    logic       clr_cnt;

    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic [7:0] par_err_cnt;
    logic [7:0] stp_err_cnt;
    logic       busy;

    logic [7:0] pDataB;
    logic       dataValidB;
    logic       parErrB;
    logic       stpErrB;
    logic [1:0] parCntB;
    logic [1:0] stpCntB;
    logic       busyB;

    int assertCount = 0;
    int failCount   = 0;
    int dvCount     = 0;
    int modelPar    = 0;
    int modelStp    = 0;

    // Frame record: stimulus fields followed by the hand-computed results.
    typedef struct {
        logic [7:0] data;
        logic       parEn;
        logic [1:0] parTyp;
        logic       stop2;
        logic       parBit;
        logic       stopBit1;
        logic       stopBit2;
        logic [7:0] expData;
        logic       expParErr;
        logic       expStpErr;
    } frame_t;

    frame_t vecs[10];

    always #5 CLK = ~CLK;

    uart_frame_check #(.DATA_W(8), .CNT_W(8)) dutA (
        .CLK(CLK), .RST(RST), .start_det(start_det), .bit_valid(bit_valid),
        .sampled_bit(sampled_bit), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .STOP2(STOP2), .clr_cnt(clr_cnt), .P_DATA(P_DATA),
        .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
        .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt), .busy(busy)
    );

    uart_frame_check #(.DATA_W(8), .CNT_W(2)) dutB (
        .CLK(CLK), .RST(RST), .start_det(start_det), .bit_valid(bit_valid),
        .sampled_bit(sampled_bit), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .STOP2(STOP2), .clr_cnt(clr_cnt), .P_DATA(pDataB),
        .data_valid(dataValidB), .par_err(parErrB), .stp_err(stpErrB),
        .par_err_cnt(parCntB), .stp_err_cnt(stpCntB), .busy(busyB)
    );

    // Count every data_valid pulse, sampled away from the active edge.
    always @(negedge CLK) begin
        if (data_valid === 1'b1) dvCount++;
    end

    // Hard stop in case something wedges the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idleCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sendBit(input logic b, input logic clr);
        bit_valid   = 1'b1;
        sampled_bit = b;
        clr_cnt     = clr;
        idleCycle();
        bit_valid   = 1'b0;
        sampled_bit = 1'b0;
        clr_cnt     = 1'b0;
    endtask

    // Everything after the start bit, with a quiet cycle between strobes.
    // clr raises clr_cnt together with the final stop-bit strobe.
    task automatic sendBody(input frame_t f, input logic clr);
        for (int i = 0; i < 8; i++) begin
            sendBit(f.data[i], 1'b0);
            idleCycle();
        end
        if (f.parEn) begin
            sendBit(f.parBit, 1'b0);
            idleCycle();
        end
        if (f.stop2) begin
            sendBit(f.stopBit1, 1'b0);
            checkOutput("no_dv_after_stop1", data_valid, 0);
            idleCycle();
            sendBit(f.stopBit2, clr);
        end else begin
            sendBit(f.stopBit1, clr);
        end
        checkOutput("dv_pulse_high", data_valid, 1);
        idleCycle();
        checkOutput("dv_pulse_low", data_valid, 0);
    endtask

    task automatic applyStimulus(input frame_t f, input logic clr);
        PAR_EN    = f.parEn;
        PAR_TYP   = f.parTyp;
        STOP2     = f.stop2;
        start_det = 1'b1;
        idleCycle();
        start_det = 1'b0;
        checkOutput("busy_in_frame", busy, 1);
        sendBody(f, clr);
    endtask

    task automatic checkFrame(input frame_t f);
        checkOutput("p_data", P_DATA, f.expData);
        checkOutput("par_err", par_err, f.expParErr);
        checkOutput("stp_err", stp_err, f.expStpErr);
        checkOutput("par_cnt_a", par_err_cnt, modelPar);
        checkOutput("stp_cnt_a", stp_err_cnt, modelStp);
        checkOutput("par_cnt_b", parCntB, (modelPar > 3) ? 3 : modelPar);
        checkOutput("stp_cnt_b", stpCntB, (modelStp > 3) ? 3 : modelStp);
        checkOutput("busy_idle", busy, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_p_data"}, P_DATA, 0);
        checkOutput({tag, "_dv"}, data_valid, 0);
        checkOutput({tag, "_par_err"}, par_err, 0);
        checkOutput({tag, "_stp_err"}, stp_err, 0);
        checkOutput({tag, "_par_cnt"}, par_err_cnt, 0);
        checkOutput({tag, "_stp_cnt"}, stp_err_cnt, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_par_cnt_b"}, parCntB, 0);
    endtask

    initial begin
        frame_t f;
        int     pre;

        // Fields: data, parEn, parTyp, stop2, parBit, stop1, stop2 bit,
        //         expData, expParErr, expStpErr
        vecs[0] = '{8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
        vecs[2] = '{8'h03, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[3] = '{8'h5A, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'hC3, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b1};
        vecs[8] = '{8'h7E, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0};
        vecs[9] = '{8'h07, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07, 1'b1, 1'b1};

        RST = 1'b1; start_det = 1'b0; bit_valid = 1'b0; sampled_bit = 1'b0;
        PAR_EN = 1'b0; PAR_TYP = 2'b00; STOP2 = 1'b0; clr_cnt = 1'b0;
        repeat (3) idleCycle();
        RST = 1'b0;
        idleCycle();
        $display("[TB] reset state");
        checkAllZero("reset");

        $display("[TB] table frames");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], 1'b0);
            if (vecs[i].expParErr) modelPar++;
            if (vecs[i].expStpErr) modelStp++;
            checkFrame(vecs[i]);
        end

        $display("[TB] bit_valid in idle");
        pre = dvCount;
        for (int i = 0; i < 3; i++) sendBit(1'b1, 1'b0);
        idleCycle();
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_dv_count", dvCount, pre);
        checkOutput("idle_p_data", P_DATA, 8'h07);

        $display("[TB] config change mid-frame");
        f = '{8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        PAR_EN = 1'b1; PAR_TYP = 2'b00; STOP2 = 1'b0;
        start_det = 1'b1;
        idleCycle();
        start_det = 1'b0;
        PAR_TYP = 2'b10; PAR_EN = 1'b0; STOP2 = 1'b1;
        sendBody(f, 1'b0);
        checkFrame(f);
        PAR_TYP = 2'b00; PAR_EN = 1'b1; STOP2 = 1'b0;

        $display("[TB] abort and restart");
        pre = dvCount;
        f = '{8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        start_det = 1'b1;
        idleCycle();
        start_det = 1'b0;
        sendBit(1'b1, 1'b0); sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0); sendBit(1'b1, 1'b0);
        checkOutput("abort_busy", busy, 1);
        start_det = 1'b1; bit_valid = 1'b1; sampled_bit = 1'b1;
        idleCycle();
        start_det = 1'b0; bit_valid = 1'b0; sampled_bit = 1'b0;
        sendBody(f, 1'b0);
        checkOutput("abort_dv_count", dvCount, pre + 1);
        checkFrame(f);

        $display("[TB] counter clear and saturation");
        clr_cnt = 1'b1;
        idleCycle();
        clr_cnt = 1'b0;
        modelPar = 0;
        modelStp = 0;
        checkOutput("clr_par_a", par_err_cnt, 0);
        checkOutput("clr_stp_a", stp_err_cnt, 0);
        checkOutput("clr_par_b", parCntB, 0);
        checkOutput("clr_stp_b", stpCntB, 0);
        f = '{8'h00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(f, 1'b0);
            modelPar++;
            checkFrame(f);
        end
        checkOutput("sat_par_b", parCntB, 3);
        applyStimulus(f, 1'b1);
        modelPar = 0;
        checkFrame(f);

        $display("[TB] reset mid-frame");
        f = '{8'h96, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h96, 1'b1, 1'b1};
        applyStimulus(f, 1'b0);
        modelPar++;
        modelStp++;
        checkFrame(f);
        PAR_EN = 1'b0; STOP2 = 1'b0;
        start_det = 1'b1;
        idleCycle();
        start_det = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sendBit(1'b1, 1'b0);
            idleCycle();
        end
        pre = dvCount;
        RST = 1'b1; start_det = 1'b1; bit_valid = 1'b1; sampled_bit = 1'b1;
        idleCycle();
        RST = 1'b0; start_det = 1'b0; bit_valid = 1'b0; sampled_bit = 1'b0;
        checkAllZero("rst_mid");
        for (int i = 0; i < 9; i++) sendBit(1'b1, 1'b0);
        idleCycle();
        checkOutput("rst_discard_dv", dvCount, pre);
        checkOutput("rst_discard_busy", busy, 0);
        checkOutput("rst_discard_p_data", P_DATA, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
